// File: rtl/soc_text_video_pkg.sv
// Shared definitions for the text-mode video source.
// Contents: pipeline latency, cell and attribute field layout, control
// register map, CTRL bit indices and the 16-colour CGA palette lookup.
package soc_text_video_pkg;

  localparam int PIPE_LAT = 4;

  // Cell layout: [7:0] character code, [15:8] attribute.
  localparam int CELL_CHAR_LSB = 0;
  localparam int CELL_ATTR_LSB = 8;

  // Attribute byte layout.
  localparam int ATTR_FG_LSB    = 0;
  localparam int ATTR_BG_LSB    = 4;
  localparam int ATTR_BLINK_BIT = 7;

  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  // Control register word offsets, address[3:2].
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_CURSOR = 2'd1,
    REG_FRAMES = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  // CTRL bit indices.
  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_CURSOR_EN = 1;
  localparam int CTRL_BLINK_EN  = 2;

  function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'h0:    c = 24'h000000;
      4'h1:    c = 24'h0000AA;
      4'h2:    c = 24'h00AA00;
      4'h3:    c = 24'h00AAAA;
      4'h4:    c = 24'hAA0000;
      4'h5:    c = 24'hAA00AA;
      4'h6:    c = 24'hAA5500;
      4'h7:    c = 24'hAAAAAA;
      4'h8:    c = 24'h555555;
      4'h9:    c = 24'h5555FF;
      4'hA:    c = 24'h55FF55;
      4'hB:    c = 24'h55FFFF;
      4'hC:    c = 24'hFF5555;
      4'hD:    c = 24'hFF55FF;
      4'hE:    c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/soc_text_video_font_rom.sv
// Synchronous glyph ROM: 256 characters x CHAR_H lines x 8 pixels.
// The glyph set is held as a constant table: 0xDB is a solid block, 0x41
// is an 'A', every other code is blank. Glyphs repeat every 16 lines when
// CHAR_H exceeds 16.
// Ports: clk; addr = {char code, glyph line}; line = 8 pixels, MSB leftmost,
// registered (one cycle latency).
module font_rom #(
  parameter int CHAR_H = 16,
  localparam int FY_W  = $clog2(CHAR_H)
) (
  input  logic              clk,
  input  logic [8+FY_W-1:0] addr,
  output logic [7:0]        line
);

  function automatic logic [7:0] glyph(input logic [7:0] code, input int fy);
    logic [7:0] g;
    g = 8'h00;
    case (code)
      8'h41: begin
        case (fy % 16)
          2, 3, 4:             g = 8'h18;
          5:                   g = 8'h3C;
          6, 7, 9, 10, 11, 12: g = 8'h66;
          8:                   g = 8'h7E;
          default:             g = 8'h00;
        endcase
      end
      8'hDB:   g = 8'hFF;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    line <= glyph(addr[8+FY_W-1:FY_W], int'(addr[FY_W-1:0]));
  end

endmodule

// File: rtl/soc_text_video.sv
// Text-mode video source with bus-accessible cell RAM and control registers.
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   sel, wren, address   bus access; wren==0 is a read; address[23] picks
//   data_in, data_out    cell RAM (1) or control registers (0)
//   xpos, ypos           pixel position from the timing generator
//   frame_end            one pulse per frame, drives FRAMES and blink
//   rgb                  {R,G,B} for the position presented 4 cycles earlier
module soc_text_video
  import soc_text_video_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  wren,
  input  logic [23:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [9:0]  xpos,
  input  logic [9:0]  ypos,
  input  logic        frame_end,
  output logic [23:0] rgb
);

  localparam int NCELLS = COLS * ROWS;
  localparam int NWORDS = (NCELLS + 1) / 2;
  localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CELL_W = WORD_W + 1;
  localparam int CX_W   = $clog2(CHAR_W);
  localparam int FY_W   = $clog2(CHAR_H);
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Control state
  logic             enable, cursor_en, blink_en;
  logic [6:0]       cur_col;
  logic [5:0]       cur_row;
  logic [15:0]      frames;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Bus decode
  logic [20:0]       bus_word;
  logic              bus_word_ok;
  logic [WORD_W-1:0] bus_widx;
  reg_sel_e          rsel;
  logic              bus_rd, bus_wr_ok;

  assign bus_word    = address[22:2];
  assign bus_word_ok = bus_word < 21'(NWORDS);
  assign bus_widx    = bus_word[WORD_W-1:0];
  assign rsel        = reg_sel_e'(address[3:2]);
  assign bus_rd      = sel && (wren == 4'b0000);
  assign bus_wr_ok   = sel && !reset;

  // Cell RAM: two cells per 32-bit word, byte-lane writes, not reset.
  logic [31:0] cell_ram [NWORDS];

  // Pixel pipeline registers
  logic [CELL_W-1:0] cell_idx_p0;
  logic [CX_W-1:0]   fx_p0, fx_p1, fx_p2;
  logic [FY_W-1:0]   fy_p0, fy_p1, fy_p2;
  logic              hit_p0, hit_p1, hit_p2;
  logic              vld_p0, vld_p1, vld_p2;
  logic              hi_p1;
  logic [31:0]       ram_q_p1;
  logic [7:0]        line_p2;
  attr_t             attr_p2;

  always_ff @(posedge clk) begin
    if (bus_wr_ok && address[23] && bus_word_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wren[b]) cell_ram[bus_widx][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
    ram_q_p1 <= cell_ram[cell_idx_p0[CELL_W-1:1]];
  end

  // Control registers, frame counter and blink phase
  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      cursor_en   <= 1'b0;
      blink_en    <= 1'b0;
      cur_col     <= '0;
      cur_row     <= '0;
      frames      <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (sel && !address[23]) begin
        case (rsel)
          REG_CTRL: begin
            if (wren[0]) begin
              enable    <= data_in[CTRL_ENABLE];
              cursor_en <= data_in[CTRL_CURSOR_EN];
              blink_en  <= data_in[CTRL_BLINK_EN];
            end
          end
          REG_CURSOR: begin
            if (wren[0]) cur_col <= data_in[6:0];
            if (wren[1]) cur_row <= data_in[13:8];
          end
          default: ;
        endcase
      end
      if (frame_end) begin
        frames <= frames + 16'd1;
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Registered bus read; RAM read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (bus_rd) begin
      if (address[23]) begin
        data_out <= bus_word_ok ? cell_ram[bus_widx] : 32'd0;
      end else begin
        case (rsel)
          REG_CTRL:   data_out <= {29'd0, blink_en, cursor_en, enable};
          REG_CURSOR: data_out <= {18'd0, cur_row, 1'b0, cur_col};
          REG_FRAMES: data_out <= {16'd0, frames};
          default:    data_out <= 32'd0;
        endcase
      end
    end
  end

  // S0: position to cell index, fine offsets, cursor hit
  logic [9:0]  col_s, row_s;
  logic [19:0] idx_full;
  logic        in_range, cur_hit;

  assign col_s    = xpos >> CX_W;
  assign row_s    = ypos >> FY_W;
  assign in_range = (col_s < 10'(COLS)) && (row_s < 10'(ROWS));
  assign idx_full = {10'd0, row_s} * 20'(COLS) + {10'd0, col_s};
  assign cur_hit  = (col_s == {3'd0, cur_col}) && (row_s == {4'd0, cur_row});

  always_ff @(posedge clk) begin
    cell_idx_p0 <= in_range ? idx_full[CELL_W-1:0] : '0;
    fx_p0       <= xpos[CX_W-1:0];
    fy_p0       <= ypos[FY_W-1:0];
    hit_p0      <= cur_hit;
  end

  // S1: cell RAM read (ram_q_p1 above); side data follows
  always_ff @(posedge clk) begin
    hi_p1  <= cell_idx_p0[0];
    fx_p1  <= fx_p0;
    fy_p1  <= fy_p0;
    hit_p1 <= hit_p0;
  end

  // S2: font ROM read for the selected half-word cell
  logic [15:0] cell_p1;
  assign cell_p1 = hi_p1 ? ram_q_p1[31:16] : ram_q_p1[15:0];

  font_rom #(.CHAR_H(CHAR_H)) u_font (
    .clk  (clk),
    .addr ({cell_p1[CELL_CHAR_LSB +: 8], fy_p1}),
    .line (line_p2)
  );

  always_ff @(posedge clk) begin
    attr_p2 <= attr_t'(cell_p1[CELL_ATTR_LSB +: 8]);
    fx_p2   <= fx_p1;
    fy_p2   <= fy_p1;
    hit_p2  <= hit_p1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= in_range;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // S3: pixel select, blink, underline cursor, blanking
  logic        pix_bit;
  logic [3:0]  cidx;
  logic [23:0] pix_rgb;

  always_comb begin
    pix_bit = line_p2[~fx_p2];
    cidx    = pix_bit ? attr_p2.fg : {1'b0, attr_p2.bg};
    if (attr_p2.blink && blink_en && blink_phase) cidx = {1'b0, attr_p2.bg};
    if (cursor_en && hit_p2 && (fy_p2 >= FY_W'(CHAR_H - 2)) &&
        (!blink_phase || !blink_en)) begin
      cidx = attr_p2.fg;
    end
    pix_rgb = (enable && vld_p2) ? palette_rgb(cidx) : 24'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) rgb <= '0;
    else       rgb <= pix_rgb;
  end

  logic unused_bits;
  assign unused_bits = ^{address[1:0], idx_full};

endmodule
